// File: rtl/ksa.sv
// RC4 key-scheduling engine: permutes a 256-byte S array held in an external
// single-port synchronous RAM, one swap per 13-cycle iteration.
module ksa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [4:0] {
        StWaitKsa     = 5'b00000,
        StCheck       = 5'b00001,
        StFunctionJ0  = 5'b00010,
        StFunctionJ1  = 5'b00011,
        StFunctionJ2  = 5'b00100,
        StCopyI       = 5'b00101,
        StChangeAddrJ = 5'b00110,
        StCopyJ       = 5'b00111,
        StSwapJ       = 5'b01000,
        StChangeAddrI = 5'b01001,
        StSwapI       = 5'b01010,
        StIncrement   = 5'b01011,
        StDoneKsa     = 5'b01100,
        StBufRddata   = 5'b01101,
        StSetLoadI    = 5'b01110,
        StBufRddataI1 = 5'b01111,
        StBufRddataI2 = 5'b10000
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  i_q, i_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;

    // rst_n is an active-high synchronous reset despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StWaitKsa;
            i_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        rdy     = 1'b0;
        wren    = 1'b0;
        wrdata  = 8'h00;
        addr    = i_q[7:0];

        unique case (state_q)
            StWaitKsa: begin
                rdy  = 1'b1;
                addr = 8'h00;
                if (en) begin
                    i_d     = '0;
                    k_d     = '0;
                    j_d     = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (i_q[8]) begin
                    state_d = StDoneKsa;
                end else begin
                    unique case (k_q)
                        2'd0:    state_d = StFunctionJ0;
                        2'd1:    state_d = StFunctionJ1;
                        default: state_d = StFunctionJ2;
                    endcase
                end
            end
            // rddata here is S[i], prefetched with addr=i during the two prior cycles
            StFunctionJ0: begin
                j_d     = j_q + rddata + key[23:16];
                state_d = StCopyI;
            end
            StFunctionJ1: begin
                j_d     = j_q + rddata + key[15:8];
                state_d = StCopyI;
            end
            StFunctionJ2: begin
                j_d     = j_q + rddata + key[7:0];
                state_d = StCopyI;
            end
            StCopyI: begin
                si_d    = rddata;
                state_d = StChangeAddrJ;
            end
            StChangeAddrJ: begin
                addr    = j_q;
                state_d = StBufRddata;
            end
            StBufRddata: begin
                addr    = j_q;
                state_d = StBufRddataI2;
            end
            StBufRddataI2: begin
                addr    = j_q;
                state_d = StCopyJ;
            end
            StCopyJ: begin
                addr    = j_q;
                sj_d    = rddata;
                state_d = StSwapJ;
            end
            StSwapJ: begin
                addr    = j_q;
                wrdata  = si_q;
                wren    = 1'b1;
                state_d = StChangeAddrI;
            end
            StChangeAddrI: begin
                state_d = StSwapI;
            end
            StSwapI: begin
                wrdata  = sj_q;
                wren    = 1'b1;
                state_d = StSetLoadI;
            end
            StSetLoadI: begin
                state_d = StIncrement;
            end
            StIncrement: begin
                i_d     = i_q + 9'd1;
                k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                state_d = StBufRddataI1;
            end
            StBufRddataI1: begin
                state_d = StCheck;
            end
            StDoneKsa: begin
                state_d = StWaitKsa;
            end
            default: begin
                state_d = StWaitKsa;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural sync RAM, software RC4 KSA model feeding a queue of
// expected RAM writes, and a per-cycle FSM state walk.
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    always #5 clk = ~clk;

    ksa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    localparam logic [4:0] S_WAIT    = 5'b00000;
    localparam logic [4:0] S_CHECK   = 5'b00001;
    localparam logic [4:0] S_FJ0     = 5'b00010;
    localparam logic [4:0] S_FJ1     = 5'b00011;
    localparam logic [4:0] S_FJ2     = 5'b00100;
    localparam logic [4:0] S_COPY_I  = 5'b00101;
    localparam logic [4:0] S_CADDR_J = 5'b00110;
    localparam logic [4:0] S_COPY_J  = 5'b00111;
    localparam logic [4:0] S_SWAP_J  = 5'b01000;
    localparam logic [4:0] S_CADDR_I = 5'b01001;
    localparam logic [4:0] S_SWAP_I  = 5'b01010;
    localparam logic [4:0] S_INC     = 5'b01011;
    localparam logic [4:0] S_DONE    = 5'b01100;
    localparam logic [4:0] S_BUF     = 5'b01101;
    localparam logic [4:0] S_SETLD   = 5'b01110;
    localparam logic [4:0] S_BUF_I1  = 5'b01111;
    localparam logic [4:0] S_BUF_I2  = 5'b10000;

    // Single-port synchronous RAM, read-old-data on a same-cycle write
    logic [7:0] mem [256];
    logic       ram_init = 1'b0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  sw [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] exp_st);
        logic [15:0] e;
        @(negedge clk);
        check_eq("state", 32'(dut.state_q), 32'(exp_st));
        if (wren) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                check_eq("wr_extra", {16'h0, addr, wrdata}, 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                check_eq("write", {16'h0, addr, wrdata}, {16'h0, e});
            end
        end
    endtask

    // Software RC4 KSA starting from the current RAM contents
    task automatic build_model(input logic [23:0] k);
        logic [7:0] j, t, kb;
        j = 8'h00;
        wr_q.delete();
        for (int n = 0; n < 256; n++) sw[n] = mem[n];
        for (int n = 0; n < 256; n++) begin
            kb = (n % 3 == 0) ? k[23:16] : (n % 3 == 1) ? k[15:8] : k[7:0];
            j  = j + sw[n] + kb;
            wr_q.push_back({j, sw[n]});
            wr_q.push_back({8'(n), sw[j]});
            t     = sw[n];
            sw[n] = sw[j];
            sw[j] = t;
        end
    endtask

    task automatic start_run(input logic [23:0] k);
        build_model(k);
        n_wr = 0;
        check_eq("rdy_idle", 32'(rdy), 32'd1);
        key = k;
        en  = 1'b1;
        step(S_CHECK);
        check_eq("rdy_busy", 32'(rdy), 32'd0);
    endtask

    task automatic run_iters(input int n_it);
        for (int it = 0; it < n_it; it++) begin
            step((it % 3 == 0) ? S_FJ0 : (it % 3 == 1) ? S_FJ1 : S_FJ2);
            step(S_COPY_I);
            step(S_CADDR_J);
            step(S_BUF);
            step(S_BUF_I2);
            step(S_COPY_J);
            step(S_SWAP_J);
            step(S_CADDR_I);
            step(S_SWAP_I);
            step(S_SETLD);
            step(S_INC);
            step(S_BUF_I1);
            step(S_CHECK);
        end
    endtask

    task automatic finish_run(input logic hold_en);
        run_iters(256);
        step(S_DONE);
        check_eq("done_rdy", 32'(rdy), 32'd0);
        check_eq("done_wren", 32'(wren), 32'd0);
        step(S_WAIT);
        check_eq("wait_rdy", 32'(rdy), 32'd1);
        check_eq("wren_count", 32'(n_wr), 32'd512);
        check_eq("wr_left", 32'(wr_q.size()), 32'd0);
        for (int n = 0; n < 256; n++) check_eq("final_ram", 32'(mem[n]), 32'(sw[n]));
        if (hold_en) begin
            step(S_CHECK);
            en = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        key      = 24'h0;
        ram_init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ram_init = 1'b0;
        check_eq("rst_state", 32'(dut.state_q), 32'(S_WAIT));
        check_eq("rst_rdy", 32'(rdy), 32'd1);
        check_eq("rst_wren", 32'(wren), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_wrdata", 32'(wrdata), 32'd0);
        rst_n = 1'b0;
        step(S_WAIT);
        step(S_WAIT);

        // Full run from identity S with key 00033C
        start_run(24'h00033C);
        en = 1'b0;
        finish_run(1'b0);

        // Abort during iteration 10, then restart over the partially permuted RAM
        start_run(24'h00033C);
        en = 1'b0;
        run_iters(10);
        step(S_FJ1);
        step(S_COPY_I);
        step(S_CADDR_J);
        rst_n = 1'b1;
        step(S_WAIT);
        check_eq("abort_wren", 32'(wren), 32'd0);
        check_eq("abort_rdy", 32'(rdy), 32'd1);
        rst_n = 1'b0;
        start_run(24'h00033C);
        en = 1'b0;
        finish_run(1'b0);

        // en held high throughout: must idle one cycle in WAIT then restart
        start_run(24'hA55A0F);
        finish_run(1'b1);

        rst_n = 1'b1;
        step(S_WAIT);
        rst_n = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
